stoch_signed_decode: RTL

//  Converts a signed stochastic bitstream pair (p/m, as produced by the signed

---
 rtl/stoch_signed_decode.sv | 60 ++++++
 1 files changed

// File: rtl/stoch_signed_decode.sv
// stoch_signed_decode: windowed p/m ones counter producing a signed p - m result behind a valid/ready register
module stoch_signed_decode #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    input  logic                   a_p,
    input  logic                   a_m,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WINDOW_LOG2+1:0] y,
    output logic                   overrun
);
    localparam int W = WINDOW_LOG2;

    logic [W:0]   cnt_p_q, cnt_p_d, cnt_m_q, cnt_m_d, p_next, m_next;
    logic [W-1:0] sample_cnt_q, sample_cnt_d;
    logic [W+1:0] y_q, y_d;
    logic         out_valid_q, out_valid_d, overrun_q, overrun_d;
    logic         accept, last;

    // Accumulate accepted samples; the window-end sample is folded into the result and restarts the counters.
    always_comb begin
        accept       = in_valid & ~clear;
        last         = accept & (sample_cnt_q == '1);
        p_next       = cnt_p_q + (W+1)'(a_p);
        m_next       = cnt_m_q + (W+1)'(a_m);
        cnt_p_d      = (clear | last) ? '0 : accept ? p_next : cnt_p_q;
        cnt_m_d      = (clear | last) ? '0 : accept ? m_next : cnt_m_q;
        sample_cnt_d = clear ? '0 : accept ? sample_cnt_q + W'(1) : sample_cnt_q;
        y_d          = last ? {1'b0, p_next} - {1'b0, m_next} : y_q;
        out_valid_d  = last | (out_valid_q & ~out_ready);
        overrun_d    = overrun_q | (last & out_valid_q & ~out_ready);
    end

    // State registers with synchronous reset that discards any partial window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_p_q      <= '0;
            cnt_m_q      <= '0;
            sample_cnt_q <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_p_q      <= cnt_p_d;
            cnt_m_q      <= cnt_m_d;
            sample_cnt_q <= sample_cnt_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
endmodule
